// File: rtl/video_timing_gen.sv
// video_timing_gen
// ----------------
// Parametrised raster timing generator for the pixel clock domain. It produces
// pixel/line counters, sync pulses, an active-video flag and line/frame start
// markers for any video mode set through the parameters.
//
// All outputs come from one register stage. The flags are computed from the
// next counter values and registered alongside the counters, so every output
// on a given cycle describes the same (h_count, v_count) position.
//
// Ports:
//   rfr_clk      pixel clock (single clock domain)
//   reset        asynchronous, active-high reset; counters return to (0,0)
//   pix_ce       pixel advance enable; every register holds while low
//   h_sync       horizontal sync, asserted level = H_SYNC_POL
//   v_sync       vertical sync, asserted level = V_SYNC_POL (line-granular)
//   h_count      pixel index 0..H_TOTAL-1
//   v_count      line index 0..V_TOTAL-1
//   video_on     high while the current position is visible
//   line_start   level marker, high while h_count == 0
//   frame_start  level marker, high while (h_count, v_count) == (0,0)
//   frame_count  16-bit completed-frame counter (VTG_FRAME_CNT_EN only)
//
// Optional feature macro: VTG_FRAME_CNT_EN adds the frame_count port and
// register. Without it the port and logic are absent.
module video_timing_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int H_SYNC_POL = 0,
  parameter int V_SYNC_POL = 0,
  parameter int CNT_W      = 12
) (
  input  logic             rfr_clk,
  input  logic             reset,
  input  logic             pix_ce,
  output logic             h_sync,
  output logic             v_sync,
  output logic [CNT_W-1:0] h_count,
  output logic [CNT_W-1:0] v_count,
  output logic             video_on,
  output logic             line_start,
  output logic             frame_start
`ifdef VTG_FRAME_CNT_EN
  ,
  output logic [15:0]      frame_count
`endif
);

  localparam int H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_SYNC_START = H_ACTIVE + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int V_SYNC_START = V_ACTIVE + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

  localparam logic H_POL = (H_SYNC_POL != 0);
  localparam logic V_POL = (V_SYNC_POL != 0);

  // Refuse to elaborate a mode whose counters cannot hold the totals or that
  // has an empty region.
  if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0 ||
      CNT_W == 0 ||
      longint'(H_TOTAL) > (longint'(1) << CNT_W) ||
      longint'(V_TOTAL) > (longint'(1) << CNT_W)) begin : g_bad_params
    $error("video_timing_gen: zero parameter or total exceeds 2**CNT_W");
  end

  logic             h_wrap;
  logic             v_wrap;
  logic [CNT_W-1:0] h_next;
  logic [CNT_W-1:0] v_next;
  logic             video_on_next;
  logic             h_sync_next;
  logic             v_sync_next;
  int               h_n;
  int               v_n;

  // Next counter position plus the flags for that position. With pix_ce low
  // the next state equals the current one, so the flags are stable too.
  // v_count only moves on the h wrap, which keeps v_sync line-granular.
  always_comb begin
    h_wrap = (h_count == H_LAST);
    v_wrap = (v_count == V_LAST);
    h_next = h_count;
    v_next = v_count;
    if (pix_ce) begin
      if (h_wrap) begin
        h_next = '0;
        v_next = v_wrap ? '0 : v_count + 1'b1;
      end else begin
        h_next = h_count + 1'b1;
      end
    end

    h_n = int'(h_next);
    v_n = int'(v_next);
    video_on_next = (h_n < H_ACTIVE) && (v_n < V_ACTIVE);
    h_sync_next   = ((h_n >= H_SYNC_START) && (h_n < H_SYNC_END)) ? H_POL : ~H_POL;
    v_sync_next   = ((v_n >= V_SYNC_START) && (v_n < V_SYNC_END)) ? V_POL : ~V_POL;
  end

  // Single register stage for counters and flags. Reset lands on (0,0),
  // which is visible, a line start and a frame start, outside both syncs.
  always_ff @(posedge rfr_clk or posedge reset) begin
    if (reset) begin
      h_count     <= '0;
      v_count     <= '0;
      video_on    <= 1'b1;
      line_start  <= 1'b1;
      frame_start <= 1'b1;
      h_sync      <= ~H_POL;
      v_sync      <= ~V_POL;
    end else if (pix_ce) begin
      h_count     <= h_next;
      v_count     <= v_next;
      video_on    <= video_on_next;
      line_start  <= (h_next == '0);
      frame_start <= (h_next == '0) && (v_next == '0);
      h_sync      <= h_sync_next;
      v_sync      <= v_sync_next;
    end
  end

`ifdef VTG_FRAME_CNT_EN
  // Counts completed frames: bumps on the edge leaving the last pixel of the
  // last line and wraps naturally at 16 bits. Only written on that edge.
  always_ff @(posedge rfr_clk or posedge reset) begin
    if (reset) begin
      frame_count <= '0;
    end else if (pix_ce && h_wrap && v_wrap) begin
      frame_count <= frame_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen
// -------------------
// Self-checking bench for video_timing_gen in a small 8x6 raster mode. The
// reference model tracks a single linear pixel index inside the frame and
// derives the expected position and flags from it with plain arithmetic.
// Define VTG_FRAME_CNT_EN to also exercise the frame counter. Override
// H_POL / V_POL to check the inverted sync polarities.
module tb_video_timing_gen #(
  parameter int H_POL = 0,
  parameter int V_POL = 0
);

  localparam int HA = 4, HFP = 1, HS = 2, HBP = 1;
  localparam int VA = 3, VFP = 1, VS = 1, VBP = 1;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int CW = 12;

  logic          rfr_clk;
  logic          reset;
  logic          pix_ce;
  logic          h_sync;
  logic          v_sync;
  logic [CW-1:0] h_count;
  logic [CW-1:0] v_count;
  logic          video_on;
  logic          line_start;
  logic          frame_start;
`ifdef VTG_FRAME_CNT_EN
  logic [15:0]   frame_count;
`endif

  int          check_count = 0;
  int          fail_count  = 0;
  int          model_pix;
  logic [15:0] model_frames;

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .H_SYNC_POL(H_POL), .V_SYNC_POL(V_POL), .CNT_W(CW)
  ) dut (
    .rfr_clk     (rfr_clk),
    .reset       (reset),
    .pix_ce      (pix_ce),
    .h_sync      (h_sync),
    .v_sync      (v_sync),
    .h_count     (h_count),
    .v_count     (v_count),
    .video_on    (video_on),
    .line_start  (line_start),
    .frame_start (frame_start)
`ifdef VTG_FRAME_CNT_EN
    ,
    .frame_count (frame_count)
`endif
  );

  // 10 ns pixel clock
  initial rfr_clk = 1'b0;
  always #5 rfr_clk = ~rfr_clk;

  // Counts one comparison and reports it if the values differ.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s observed=%0d expected=%0d (model h=%0d v=%0d)",
               tag, observed, expected, model_pix % HT, model_pix / HT);
    end
  endtask

  // Compares every output with what the model position implies.
  task automatic compareAll(input string tag);
    int  h;
    int  v;
    logic exp_hs;
    logic exp_vs;
    h = model_pix % HT;
    v = model_pix / HT;
    exp_hs = (h >= HA + HFP && h < HA + HFP + HS) ? (H_POL != 0) : (H_POL == 0);
    exp_vs = (v >= VA + VFP && v < VA + VFP + VS) ? (V_POL != 0) : (V_POL == 0);
    checkOutput({tag, ".h_count"},     32'(h_count),     32'(h));
    checkOutput({tag, ".v_count"},     32'(v_count),     32'(v));
    checkOutput({tag, ".video_on"},    32'(video_on),    32'(h < HA && v < VA));
    checkOutput({tag, ".h_sync"},      32'(h_sync),      32'(exp_hs));
    checkOutput({tag, ".v_sync"},      32'(v_sync),      32'(exp_vs));
    checkOutput({tag, ".line_start"},  32'(line_start),  32'(h == 0));
    checkOutput({tag, ".frame_start"}, 32'(frame_start), 32'(model_pix == 0));
`ifdef VTG_FRAME_CNT_EN
    checkOutput({tag, ".frame_count"}, 32'(frame_count), 32'(model_frames));
`endif
  endtask

  // One clock: drive pix_ce, let the edge happen, advance the model if the
  // edge was a qualified one, then check at the falling edge.
  task automatic stepCycle(input string tag, input logic ce);
    pix_ce = ce;
    @(posedge rfr_clk);
    if (ce && !reset) begin
      if (model_pix == HT * VT - 1) begin
        model_pix    = 0;
        model_frames = model_frames + 16'd1;
      end else begin
        model_pix = model_pix + 1;
      end
    end
    @(negedge rfr_clk);
    compareAll(tag);
  endtask

  // Runs n cycles with pix_ce held high or randomised.
  task automatic applyStimulus(input string tag, input int n, input bit rnd);
    for (int i = 0; i < n; i++) begin
      stepCycle(tag, rnd ? 1'($urandom_range(0, 1)) : 1'b1);
    end
  endtask

  initial begin
    reset        = 1'b1;
    pix_ce       = 1'b0;
    model_pix    = 0;
    model_frames = 16'd0;
    repeat (2) @(negedge rfr_clk);
    compareAll("reset");
    reset = 1'b0;

    $display("[TB] first line and first full frame");
    applyStimulus("line0", 8, 1'b0);
    applyStimulus("frame0", HT * VT - 8, 1'b0);

    $display("[TB] pix_ce hold from (3,0)");
    applyStimulus("to30", 3, 1'b0);
    stepCycle("ce1a", 1'b1);
    stepCycle("ce0a", 1'b0);
    stepCycle("ce0b", 1'b0);
    stepCycle("ce1b", 1'b1);

    $display("[TB] randomised pix_ce");
    applyStimulus("rand", 400, 1'b1);

    $display("[TB] reset in the middle of v sync");
    for (int i = 0; i < HT * VT && model_pix != 4 * HT + 6; i++) begin
      stepCycle("seek", 1'b1);
    end
    checkOutput("seek.pos", 32'(model_pix), 32'(4 * HT + 6));
    reset = 1'b1;
    #1;
    model_pix    = 0;
    model_frames = 16'd0;
    compareAll("async_rst");
    stepCycle("rst_hold", 1'b1);
    reset = 1'b0;
    applyStimulus("post_rst", 60, 1'b1);

`ifdef VTG_FRAME_CNT_EN
    $display("[TB] frame counter");
    reset = 1'b1;
    #1;
    model_pix    = 0;
    model_frames = 16'd0;
    @(negedge rfr_clk);
    reset = 1'b0;
    compareAll("fc_rst");
    applyStimulus("fc3", 3 * HT * VT, 1'b0);
    checkOutput("fc.three", 32'(frame_count), 32'd3);
    force dut.frame_count = 16'hFFFF;
    #1;
    release dut.frame_count;
    model_frames = 16'hFFFF;
    applyStimulus("fcwrap", HT * VT, 1'b0);
    checkOutput("fc.wrap", 32'(frame_count), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Parametrised raster timing generator; successor to the fixed-mode VGA timing controller. It produces horizontal/vertical counters, sync pulses, an active-video flag and line/frame start markers for any mode set by parameters, with configurable sync polarity and a pixel clock-enable. It sits between the pixel clock domain and the pixel/framebuffer fetch logic. Every output is registered and aligned to the same counter state.

## Interface
Parameters:
- H_ACTIVE, 640: visible pixels per line
- H_FP, 16: horizontal front porch (pixels)
- H_SYNC, 96: horizontal sync width (pixels)
- H_BP, 48: horizontal back porch (pixels)
- V_ACTIVE, 480: visible lines per frame
- V_FP, 10: vertical front porch (lines)
- V_SYNC, 2: vertical sync width (lines)
- V_BP, 33: vertical back porch (lines)
- H_SYNC_POL, 0: asserted level of h_sync (0 = active-low)
- V_SYNC_POL, 0: asserted level of v_sync
- CNT_W, 12: counter width

Ports:
- rfr_clk  in  1  pixel clock; single clock domain
- reset  in  1  asynchronous, active-high reset
- pix_ce  in  1  pixel advance enable; state holds when 0
- h_sync  out  1  horizontal sync, polarity per H_SYNC_POL
- v_sync  out  1  vertical sync, polarity per V_SYNC_POL
- h_count  out  CNT_W  current pixel index, 0..H_TOTAL-1
- v_count  out  CNT_W  current line index, 0..V_TOTAL-1
- video_on  out  1  high iff current (h_count, v_count) is visible
- line_start  out  1  high iff h_count == 0
- frame_start  out  1  high iff h_count == 0 and v_count == 0
- frame_count  out  16  frame counter (only with VTG_FRAME_CNT_EN)

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Elaboration fails (assertion) if either total > 2^CNT_W or any parameter is 0.
- Horizontal regions by h_count: active [0, H_ACTIVE); front porch [H_ACTIVE, H_ACTIVE+H_FP); sync [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); back porch to H_TOTAL-1. Vertical regions are identical, using v_count and the V_* parameters.
- On each rfr_clk edge with pix_ce=1: if h_count == H_TOTAL-1, h_count→0 and v_count advances; otherwise h_count+1. v_count advances as v_count == V_TOTAL-1 ? 0 : v_count+1.
- With pix_ce=0: all registers hold, so outputs are unchanged.
- Derived outputs are computed from the next counter values and registered, so on any cycle they describe the h_count/v_count presented on that cycle:
  - video_on = h active AND v active.
  - h_sync = H_SYNC_POL while in the h sync region, else ~H_SYNC_POL.
  - v_sync = V_SYNC_POL while in the v sync region, else ~V_SYNC_POL. v_sync is line-granular and changes only at h_count wrap.
- line_start and frame_start are level markers. They stay high across multiple rfr_clk cycles when pix_ce is low; consumers qualify them with pix_ce.

## Timing
- Reset values, asserted asynchronously, counters at (0,0):
  - h_count=0, v_count=0
  - video_on=1, line_start=1, frame_start=1
  - h_sync=~H_SYNC_POL, v_sync=~V_SYNC_POL
  - frame_count=0
- Reset asserted mid-frame forces all outputs to the reset values immediately. The first advance after release requires pix_ce=1 on an edge with reset low.
- Latency: zero between counter and flags, since they share the register stage. A frame is H_TOTAL*V_TOTAL pix_ce-qualified cycles.
- Simultaneous wrap: the cycle that leaves (H_TOTAL-1, V_TOTAL-1) yields (0,0), with frame_start=1 and video_on=1 on that same cycle.

## Configuration
- VTG_FRAME_CNT_EN defined:
  - frame_count port and register are present.
  - frame_count increments by 1 on the pix_ce edge that wraps (H_TOTAL-1, V_TOTAL-1) → (0,0).
  - It wraps 0xFFFF → 0x0000 and is reset to 0.
- VTG_FRAME_CNT_EN undefined: the frame_count port and logic are absent. All other behaviour is identical.

## Test plan
Small mode used throughout: H_ACTIVE=4, H_FP=1, H_SYNC=2, H_BP=1 (H_TOTAL=8); V_ACTIVE=3, V_FP=1, V_SYNC=1, V_BP=1 (V_TOTAL=6).
- Reset then pix_ce=1 for 8 cycles:
  - h_count reads 0..7, then 0 with v_count=1.
  - video_on=1 for h 0..3 and 0 for h 4..7.
  - h_sync=1 (active-low pol) except h 5..6, where it is 0.
- Run 48 pix_ce cycles:
  - v_sync=0 exactly for v_count=4 (8 cycles).
  - video_on=0 for v 3..5.
  - frame_start=1 only at (0,0), on cycle 0 and cycle 48.
- Toggle pix_ce 1,0,0,1 from (3,0): counters read (4,0),(4,0),(4,0),(5,0) and video_on reads 0,0,0,0.
- Assert reset at (6,4) mid-sync: on the same cycle outputs show (0,0), video_on=1, h_sync=1, v_sync=1, frame_start=1.
- Rebuild with H_SYNC_POL=1, V_SYNC_POL=1: sync levels invert vs the first two scenarios. Counters and video_on are unchanged.
- With VTG_FRAME_CNT_EN: run 3 full frames (144 pix_ce cycles) and frame_count reads 3. Preload 0xFFFF via force, wrap one frame, and frame_count reads 0.
